mac_accumulator: RTL and testbench

Sequential accumulate stage that sits directly downstream of the signed `multiplier`. It consumes a stream of sign-extended products (`outWidth` bits), sums exactly `numTerms` of them into a saturating `accWidth`-bit signed accumulator, and presents each finished sum on a valid/ready output. Together with the multiplier it forms the MAC datapath used for dot-product and FIR computations.

---
 rtl/mac_pkg.sv | 18 +
 rtl/sat_adder.sv | 25 ++
 rtl/mac_accumulator.sv | 101 ++++++++++
 tb/tb_mac_accumulator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage.
package mac_pkg;

  typedef enum logic {ACC, DONE} state_t;

  localparam int OUT_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF = 24;
  localparam int NUM_TERMS_DEF = 8;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational saturating add of a sign-extended product onto the accumulator.
module sat_adder
  import mac_pkg::*;
#(
  parameter int outWidth = OUT_WIDTH_DEF,
  parameter int accWidth = ACC_WIDTH_DEF
) (
  input  logic [accWidth-1:0] acc,
  input  logic [outWidth-1:0] inData,
  output logic [accWidth-1:0] sum,
  output logic                ovf
);

  localparam logic [accWidth-1:0] MAX_V = accWidth'(sat_max(accWidth));
  localparam logic [accWidth-1:0] MIN_V = accWidth'(sat_min(accWidth));

  logic [accWidth:0] wide;

  // One guard bit is enough: the product never exceeds the accumulator width.
  assign wide = {acc[accWidth-1], acc}
              + {{(accWidth + 1 - outWidth){inData[outWidth-1]}}, inData};
  assign ovf  = wide[accWidth] ^ wide[accWidth-1];
  assign sum  = ovf ? (wide[accWidth] ? MIN_V : MAX_V) : wide[accWidth-1:0];

endmodule

// File: rtl/mac_accumulator.sv
// Sums numTerms signed products into a saturating accumulator and hands each
// finished sum downstream over a valid/ready handshake.
//   state | meaning
//   ACC   | accepting products, building the running sum
//   DONE  | result presented on outData, waiting for outReady
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int outWidth = OUT_WIDTH_DEF,
  parameter int accWidth = ACC_WIDTH_DEF,
  parameter int numTerms = NUM_TERMS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inValid,
  output logic                inReady,
  input  logic [outWidth-1:0] inData,
  output logic                outValid,
  input  logic                outReady,
  output logic [accWidth-1:0] outData,
  output logic                ovf
);

  localparam int CNT_W = (numTerms > 1) ? $clog2(numTerms) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(numTerms - 1);

  state_t              state;
  logic [accWidth-1:0] acc;
  logic [accWidth-1:0] sum;
  logic                sum_ovf;
  logic                ovf_int;
  logic [CNT_W-1:0]    cnt;
  logic                accept;

  sat_adder #(
    .outWidth(outWidth),
    .accWidth(accWidth)
  ) u_sat_adder (
    .acc   (acc),
    .inData(inData),
    .sum   (sum),
    .ovf   (sum_ovf)
  );

  assign accept = inValid && inReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      ovf      <= 1'b0;
      outData  <= '0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else if (clr) begin
      // Abort wins over everything, including an input offered this cycle.
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      ovf      <= 1'b0;
      outData  <= '0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc     <= sum;
            ovf_int <= ovf_int | sum_ovf;
            if (cnt == LAST) begin
              state    <= DONE;
              cnt      <= '0;
              outData  <= sum;
              ovf      <= ovf_int | sum_ovf;
              outValid <= 1'b1;
              inReady  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (outReady) begin
            state    <= ACC;
            acc      <= '0;
            ovf_int  <= 1'b0;
            ovf      <= 1'b0;
            outValid <= 1'b0;
            inReady  <= 1'b1;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Three accumulators (acc widths 24/16/18) share one stimulus stream; a
// scoreboard per instance is filled by an arithmetic model and drained by a monitor.
module tb_mac_accumulator;

  typedef struct packed {
    logic [63:0] d;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  ovf;
  logic [23:0] od24;
  logic [15:0] od16;
  logic [17:0] od18;

  int checks = 0;
  int passes = 0;

  exp_t   q[3][$];
  longint macc[3];
  bit     mov[3];
  int     mcnt = 0;
  bit     pending = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.outWidth(16), .accWidth(24), .numTerms(8)) u_acc24 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inValid(in_valid), .inReady(in_ready[0]),
    .inData(in_data), .outValid(out_valid[0]), .outReady(out_ready), .outData(od24), .ovf(ovf[0]));
  mac_accumulator #(.outWidth(16), .accWidth(16), .numTerms(8)) u_acc16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inValid(in_valid), .inReady(in_ready[1]),
    .inData(in_data), .outValid(out_valid[1]), .outReady(out_ready), .outData(od16), .ovf(ovf[1]));
  mac_accumulator #(.outWidth(16), .accWidth(18), .numTerms(8)) u_acc18 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inValid(in_valid), .inReady(in_ready[2]),
    .inData(in_data), .outValid(out_valid[2]), .outReady(out_ready), .outData(od18), .ovf(ovf[2]));

  function automatic int accw(input int k);
    case (k)
      0: return 24;
      1: return 16;
      default: return 18;
    endcase
  endfunction

  function automatic longint od_s(input int k);
    case (k)
      0: return longint'($signed(od24));
      1: return longint'($signed(od16));
      default: return longint'($signed(od18));
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      macc[k] = 0;
      mov[k] = 0;
    end
    mcnt = 0;
    pending = 0;
  endtask

  // Reference behaviour at one rising edge, from the inputs held across it.
  task automatic model_step();
    longint s, mx, mn;
    exp_t e;
    if (!rst_n) return;
    if (clr) begin
      if (pending) for (int k = 0; k < 3; k++) void'(q[k].pop_back());
      model_clear();
    end else if (!pending) begin
      if (in_valid) begin
        for (int k = 0; k < 3; k++) begin
          mx = (64'sd1 <<< (accw(k) - 1)) - 1;
          mn = -(64'sd1 <<< (accw(k) - 1));
          s = macc[k] + longint'($signed(in_data));
          if (s > mx) begin s = mx; mov[k] = 1; end
          if (s < mn) begin s = mn; mov[k] = 1; end
          macc[k] = s;
        end
        mcnt++;
        if (mcnt == 8) begin
          for (int k = 0; k < 3; k++) begin
            e.d = macc[k];
            e.o = mov[k];
            q[k].push_back(e);
            macc[k] = 0;
            mov[k] = 0;
          end
          mcnt = 0;
          pending = 1;
        end
      end
    end else if (out_ready) begin
      pending = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic c);
    in_valid = v;
    in_data = d;
    out_ready = r;
    clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed(input int n, input int val, input logic r);
    for (int i = 0; i < n; i++) drive(1'b1, 16'(val), r, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_outValid[%0d]", tag, k), longint'(out_valid[k]), 0);
      chk($sformatf("%s_outData[%0d]", tag, k), od_s(k), 0);
      chk($sformatf("%s_ovf[%0d]", tag, k), longint'(ovf[k]), 0);
    end
  endtask

  // Assert reset between edges and look at the outputs before any clock arrives.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    model_clear();
    #1 check_reset_outputs(tag);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("inReady[%0d]", k), longint'(in_ready[k]), longint'(!pending));
        chk($sformatf("outValid[%0d]", k), longint'(out_valid[k]), longint'(pending));
        if (out_valid[k]) begin
          if (q[k].size() == 0) begin
            checks++;
            $display("FAIL unexpected_result[%0d]: got %0d, expected no result", k, od_s(k));
          end else begin
            e = q[k][0];
            chk($sformatf("outData[%0d]", k), od_s(k), longint'($signed(e.d)));
            chk($sformatf("ovf[%0d]", k), longint'(ovf[k]), longint'(e.o));
            if (out_ready && !clr) void'(q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

  initial begin
    model_clear();
    #2 check_reset_outputs("in_reset");
    #10 rst_n = 1'b1;
    #1 check_reset_outputs("after_reset");
    for (int k = 0; k < 3; k++) chk($sformatf("reset_inReady[%0d]", k), longint'(in_ready[k]), 1);

    // basic 1..8 -> 36
    for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
    idle(3);

    // signed terms with backpressure while input is still offered -> -49
    feed(1, -100, 1'b0); feed(1, 50, 1'b0); feed(1, -3, 1'b0); feed(1, 3, 1'b0);
    feed(3, 0, 1'b0); feed(1, 1, 1'b0);
    feed(6, 5, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    idle(2);

    // positive saturation, then a clean result right after
    feed(8, 16384, 1'b1);
    idle(1);
    feed(8, 1, 1'b1);
    idle(2);

    // negative saturation
    feed(8, -32768, 1'b1);
    idle(2);

    // clr with an offered input mid-stream
    feed(5, 7, 1'b1);
    drive(1'b1, 16'd7, 1'b1, 1'b1);
    feed(8, 2, 1'b1);
    idle(2);

    // clr while a result is pending
    feed(8, 11, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    idle(1);

    // async reset mid-accumulation, then a full result from zero
    feed(3, 100, 1'b1);
    async_reset("rst_mid_acc");
    feed(8, 5, 1'b1);
    idle(2);

    // async reset while in DONE
    feed(8, 9, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    async_reset("rst_in_done");
    feed(8, 3, 1'b1);
    idle(2);

    // randomized traffic, biased toward large magnitudes to exercise clamping
    for (int i = 0; i < 800; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 15))) - 16'sd8);
      drive(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
    end

    idle(4);
    for (int k = 0; k < 3; k++) chk($sformatf("drained[%0d]", k), longint'(q[k].size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
